// File: rtl/line_buf_pkg.sv
// Shared constants and types for the ping-pong line buffer controller.
// Bank select is the RAM address MSB; each bank holds one line.
package line_buf_pkg;

    localparam int unsigned ADDR_WIDTH     = 11;
    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned CNT_WIDTH      = ADDR_WIDTH - 1;
    localparam int unsigned LEN_WIDTH      = ADDR_WIDTH;
    localparam int unsigned BANK_DEPTH     = 2 ** CNT_WIDTH;
    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned FIFO_CNT_WIDTH = 2;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic                  eol;
        logic [DATA_WIDTH-1:0] data;
    } pix_t;

endpackage

// File: rtl/line_out_fifo.sv
// Two-entry {eol,data} output FIFO; head entry is always slot 0 so the
// output comes straight from a register.
module line_out_fifo
    import line_buf_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  pix_t                      push_data,
    input  logic                      pop,
    output pix_t                      head,
    output logic                      vld,
    output logic [FIFO_CNT_WIDTH-1:0] cnt
);

    pix_t                      head_q, head_d;
    pix_t                      tail_q, tail_d;
    logic [FIFO_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      vld_q, vld_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) head_d = push_data;
                else             tail_d = push_data;
                cnt_d = cnt_q + FIFO_CNT_WIDTH'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - FIFO_CNT_WIDTH'(1);
            end
            2'b11: begin
                if (cnt_q == FIFO_CNT_WIDTH'(1)) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
        vld_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    assign head = head_q;
    assign vld  = vld_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/line_pingpong_ctrl.sv
// Ping-pong line buffer controller: writer fills one RAM bank with a line
// while the reader drains the other full bank through a 2-entry FIFO.
module line_pingpong_ctrl
    import line_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_eol,
    output logic                  in_rdy,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_eol,
    input  logic                  out_rdy,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [1:0]            bank_full,
    output logic                  ovf_err
);

    localparam int unsigned OCC_WIDTH = FIFO_CNT_WIDTH + 1;

    logic                      accept_c, line_end_c, clear_c;
    logic                      wr_bank_q, wr_bank_d;
    logic [CNT_WIDTH-1:0]      wr_cnt_q, wr_cnt_d;
    logic [1:0][LEN_WIDTH-1:0] len_q, len_d;
    logic [1:0]                bank_full_q, bank_full_d;
    logic                      ovf_q, ovf_d;
    logic                      in_rdy_q, in_rdy_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;

    rd_state_e                 state_q, state_d;
    logic                      rd_bank_q, rd_bank_d;
    logic [CNT_WIDTH-1:0]      rd_cnt_q, rd_cnt_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_eol_q, inflight_eol_d;
    logic                      issue_c, last_c, room_c, pop_c;

    logic [FIFO_CNT_WIDTH-1:0] fifo_cnt;
    logic                      fifo_vld;
    pix_t                      fifo_head;
    pix_t                      push_pix;

    // Write side: an overflowing pixel closes the line exactly like an eol.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        bank_full_d = bank_full_q;
        ovf_d       = ovf_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        accept_c    = in_vld & in_rdy_q;
        line_end_c  = in_eol | (wr_cnt_q == CNT_WIDTH'(BANK_DEPTH - 1));
        if (accept_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, wr_cnt_q};
            wr_data_d = in_data;
            if (line_end_c) begin
                len_d[wr_bank_q]       = LEN_WIDTH'(wr_cnt_q) + LEN_WIDTH'(1);
                bank_full_d[wr_bank_q] = 1'b1;
                wr_cnt_d               = '0;
                wr_bank_d              = ~wr_bank_q;
                if (!in_eol) ovf_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
            end
        end
        if (clear_c) bank_full_d[rd_bank_q] = 1'b0;
        in_rdy_d = ~bank_full_d[wr_bank_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            bank_full_q <= '0;
            ovf_q       <= 1'b0;
            in_rdy_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            bank_full_q <= bank_full_d;
            ovf_q       <= ovf_d;
            in_rdy_q    <= in_rdy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Issue only while FIFO occupancy plus the in-flight read stays within depth.
    assign pop_c  = fifo_vld & out_rdy;
    assign last_c = (LEN_WIDTH'(rd_cnt_q) + LEN_WIDTH'(1)) == len_q[rd_bank_q];
    assign room_c = (OCC_WIDTH'(fifo_cnt) + OCC_WIDTH'(inflight_q))
                  < (OCC_WIDTH'(FIFO_DEPTH) + OCC_WIDTH'(pop_c));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= R_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (bank_full_q[rd_bank_q])      state_d = R_READ;
            R_READ:  if (issue_c && last_c)           state_d = R_DRAIN;
            R_DRAIN: if (inflight_q && inflight_eol_q) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        issue_c        = 1'b0;
        clear_c        = 1'b0;
        rd_cnt_d       = rd_cnt_q;
        rd_bank_d      = rd_bank_q;
        inflight_d     = 1'b0;
        inflight_eol_d = inflight_eol_q;
        case (state_q)
            R_IDLE: rd_cnt_d = '0;
            R_READ: begin
                if (room_c) begin
                    issue_c        = 1'b1;
                    inflight_d     = 1'b1;
                    inflight_eol_d = last_c;
                    rd_cnt_d       = rd_cnt_q + CNT_WIDTH'(1);
                end
            end
            R_DRAIN: begin
                if (inflight_q && inflight_eol_q) begin
                    clear_c   = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank_q      <= 1'b0;
            rd_cnt_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_eol_q <= 1'b0;
        end else begin
            rd_bank_q      <= rd_bank_d;
            rd_cnt_q       <= rd_cnt_d;
            inflight_q     <= inflight_d;
            inflight_eol_q <= inflight_eol_d;
        end
    end

    assign push_pix = {inflight_eol_q, ram_rd_data};

    line_out_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (push_pix),
        .pop       (pop_c),
        .head      (fifo_head),
        .vld       (fifo_vld),
        .cnt       (fifo_cnt)
    );

    assign in_rdy      = in_rdy_q;
    assign out_vld     = fifo_vld;
    assign out_data    = fifo_head.data;
    assign out_eol     = fifo_head.eol;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_rd_addr = {rd_bank_q, rd_cnt_q};
    assign bank_full   = bank_full_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_line_pingpong_ctrl.sv
// Scoreboard bench for line_pingpong_ctrl with a behavioural 2048x8 line RAM.
module tb_line_pingpong_ctrl;

    logic        clk, rst_n;
    logic        in_vld, in_eol, in_rdy;
    logic [7:0]  in_data;
    logic        out_vld, out_eol, out_rdy;
    logic [7:0]  out_data;
    logic        ram_wr_en;
    logic [10:0] ram_wr_addr, ram_rd_addr;
    logic [7:0]  ram_wr_data, ram_rd_data;
    logic [1:0]  bank_full;
    logic        ovf_err;

    line_pingpong_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_data(in_data), .in_eol(in_eol), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_data(out_data), .out_eol(out_eol), .out_rdy(out_rdy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .bank_full(bank_full), .ovf_err(ovf_err)
    );

    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stalls = 0;
    bit mon_en = 1'b0;

    logic [18:0] exp_wr[$];   // {addr, data}
    logic [8:0]  exp_out[$];  // {eol, data}
    int          runs[$];

    logic        mdl_bank;
    logic [9:0]  mdl_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    // Drive one pixel, wait for acceptance, then record expected RAM write and output.
    task automatic send(input logic [7:0] d, input logic e);
        int  g = 0;
        logic close;
        in_vld = 1'b1; in_data = d; in_eol = e;
        @(negedge clk);
        while (!in_rdy && g < 5000) begin
            g++; stalls++;
            @(negedge clk);
        end
        if (g >= 5000) begin
            chk("send_timeout", 32'(g), 32'd0);
        end else begin
            @(posedge clk); #1;
            close = e || (mdl_cnt == 10'd1023);
            exp_wr.push_back({mdl_bank, mdl_cnt, d});
            exp_out.push_back({close, d});
            if (close) begin
                mdl_bank = ~mdl_bank;
                mdl_cnt  = '0;
            end else begin
                mdl_cnt = mdl_cnt + 10'd1;
            end
        end
        in_vld = 1'b0; in_eol = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while ((exp_out.size() != 0 || exp_wr.size() != 0 || bank_full != 2'b00) && g < 6000) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_out_left"}, 32'(exp_out.size()), 32'd0);
        chk({nm, "_banks"}, 32'(bank_full), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_wr.delete(); exp_out.delete();
        mdl_bank = 1'b0; mdl_cnt = '0;
        @(posedge clk); #1;
    endtask

    // Monitor: RAM writes, output pops, stall stability and out_vld run lengths.
    logic        stall_prev = 1'b0;
    logic [8:0]  hold_pix;
    int          run_len = 0;
    logic [18:0] w;
    logic [8:0]  o;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ram_wr_en) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'(ram_wr_addr), 32'hFFFF);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(ram_wr_addr), 32'(w[18:8]));
                    chk("wr_data", 32'(ram_wr_data), 32'(w[7:0]));
                end
            end
            if (out_vld && stall_prev) chk("hold", 32'({out_eol, out_data}), 32'(hold_pix));
            if (out_vld && out_rdy) begin
                if (exp_out.size() == 0) chk("out_unexpected", 32'(out_data), 32'hFFFF);
                else begin
                    o = exp_out.pop_front();
                    chk("out_data", 32'(out_data), 32'(o[7:0]));
                    chk("out_eol", 32'(out_eol), 32'(o[8]));
                end
            end
            stall_prev = out_vld & ~out_rdy;
            hold_pix   = {out_eol, out_data};
            if (out_vld) run_len++;
            else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
        end else begin
            stall_prev = 1'b0;
            run_len    = 0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int g;
        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_eol = 1'b0; out_rdy = 1'b0;
        mdl_bank = 1'b0; mdl_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 32'(in_rdy), 32'd1);
        mon_en = 1'b1;

        // 1: single line and eol-to-out_vld latency
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), i == 3);
        acc = cyc;
        g = 0;
        while (g < 20) begin
            @(negedge clk);
            if (out_vld) break;
            g++;
        end
        chk("latency", 32'(cyc - acc), 32'd3);
        drain("t1");
        do_reset();

        // 2: fill both banks with out_rdy low, then release
        out_rdy = 1'b0;
        for (int i = 0; i < 1024; i++) send(8'(i), i == 1023);
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
        repeat (4) @(posedge clk);
        #1;
        chk("t2_full", 32'(bank_full), 32'd3);
        chk("t2_rdy_low", 32'(in_rdy), 32'd0);
        out_rdy = 1'b1;
        g = 0;
        while (bank_full[0] && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("t2_release_rdy", 32'(in_rdy), 32'd1);
        chk("t2_release_full", 32'(bank_full), 32'd2);
        drain("t2");
        do_reset();

        // 3: alternating backpressure
        out_rdy = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send(8'(i), i == 7);
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    out_rdy = ~out_rdy;
                end
            end
        join
        out_rdy = 1'b1;
        drain("t3");
        do_reset();

        // 4: overflow closes line at 1024 pixels
        out_rdy = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            send(8'(i), 1'b0);
            if (i == 1022) chk("ovf_before", 32'(ovf_err), 32'd0);
            if (i == 1023) chk("ovf_after", 32'(ovf_err), 32'd1);
        end
        send(8'hEE, 1'b1);
        drain("t4");
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(ovf_err), 32'd0);

        // 5: reset in the middle of reading out a line
        out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), i == 15);
        g = 0;
        while (!out_vld && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_wr.delete(); exp_out.delete();
        mdl_bank = 1'b0; mdl_cnt = '0;
        chk("t5_out_vld", 32'(out_vld), 32'd0);
        chk("t5_bank_full", 32'(bank_full), 32'd0);
        chk("t5_no_write", 32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        chk("t5_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 3; i++) send(8'h55 + 8'(i), i == 2);
        drain("t5");
        do_reset();

        // 6: two back-to-back full lines at full rate
        out_rdy = 1'b1;
        stalls = 0;
        runs.delete();
        for (int i = 0; i < 2048; i++) send(8'(i * 3), (i % 1024) == 1023);
        chk("t6_stalls", 32'(stalls), 32'd0);
        drain("t6");
        chk("t6_runs", 32'(runs.size()), 32'd2);
        foreach (runs[k]) chk("t6_run_len", 32'(runs[k]), 32'd1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
